// File: rtl/stack_mc_if.sv
// stack_mc_if: controller bus (Opcode/mem_ready in; datapath strobes, ALUOperation, depth, halted, trap, trap_cause out)
interface stack_mc_if #(parameter int DW = 5);
  logic [3:0] Opcode;
  logic mem_ready;
  logic IorD, MtoS, srcA, srcB, PCwrite, PCwritecond, PCsrc, IRwrite;
  logic MemRead, MemWrite, ldA, ldB, push, pop, tos;
  logic [2:0] ALUOperation;
  logic [DW-1:0] depth;
  logic halted, trap;
  logic [1:0] trap_cause;
  modport master (
    input Opcode, mem_ready,
    output IorD, MtoS, srcA, srcB, PCwrite, PCwritecond, PCsrc, IRwrite,
    output MemRead, MemWrite, ldA, ldB, push, pop, tos,
    output ALUOperation, depth, halted, trap, trap_cause
  );
  modport slave (
    output Opcode, mem_ready,
    input IorD, MtoS, srcA, srcB, PCwrite, PCwritecond, PCsrc, IRwrite,
    input MemRead, MemWrite, ldA, ldB, push, pop, tos,
    input ALUOperation, depth, halted, trap, trap_cause
  );
endinterface

// File: rtl/stack_mc_controller_p.sv
// stack_mc_controller_p: multi-cycle stack CPU controller with depth tracking and traps; ports clk, rst, ctl (stack_mc_if.master)
module stack_mc_controller_p #(
  parameter int DEPTH = 16,
  parameter int DW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  stack_mc_if.master ctl
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOT = 4'd3,
                         OP_PUSH = 4'd4, OP_POP = 4'd5, OP_JMP = 4'd6, OP_JZ = 4'd7,
                         OP_OR = 4'd8, OP_DUP = 4'd9, OP_HALT = 4'd10;
  typedef enum logic [4:0] {
    S_IF, S_DEC, S_JUMP, S_JUMPZ, S_PUSH1, S_PUSH2, S_POP1, S_POP2, S_POP3,
    S_R0, S_R1, S_R2, S_RNOT, S_REND, S_DUPA, S_DUP1, S_DUP2, S_HALT, S_TRAP
  } state_t;
  state_t state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0] cause_q, cause_d;
  logic [3:0] op;
  logic mr, is_bin, need1, illegal, under, over;
  logic [1:0] fault;
  assign op = ctl.Opcode;
  assign mr = ctl.mem_ready;
  assign is_bin = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign need1 = op inside {OP_NOT, OP_POP, OP_DUP, OP_JMP, OP_JZ};
  assign illegal = op > OP_HALT;
  assign under = is_bin ? depth_q < DW'(2) : need1 && depth_q == '0;
  assign over = (op == OP_PUSH || op == OP_DUP) && depth_q == DW'(DEPTH);
  assign fault = illegal ? 2'b11 : under ? 2'b01 : over ? 2'b10 : 2'b00;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IF: state_d = mr ? S_DEC : S_IF;
      S_DEC: begin
        state_d = fault != 2'b00 ? S_TRAP :
                  op == OP_JMP ? S_JUMP :
                  op == OP_JZ ? S_JUMPZ :
                  op == OP_PUSH ? S_PUSH1 :
                  op == OP_HALT ? S_HALT : S_POP1;
        cause_d = fault != 2'b00 ? fault : cause_q;
      end
      S_JUMP, S_JUMPZ, S_PUSH2, S_REND, S_DUP2: state_d = S_IF;
      S_PUSH1: state_d = mr ? S_PUSH2 : S_PUSH1;
      S_POP1: state_d = S_POP2;
      S_POP2: state_d = op == OP_POP ? S_POP3 : op == OP_NOT ? S_RNOT : op == OP_DUP ? S_DUPA : S_R0;
      S_POP3: state_d = mr ? S_IF : S_POP3;
      S_R0: state_d = S_R1;
      S_R1: state_d = S_R2;
      S_R2, S_RNOT: state_d = S_REND;
      S_DUPA: state_d = S_DUP1;
      S_DUP1: state_d = S_DUP2;
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    ctl.IorD = 1'b0;
    ctl.MtoS = 1'b0;
    ctl.srcA = 1'b0;
    ctl.srcB = 1'b0;
    ctl.PCwrite = 1'b0;
    ctl.PCwritecond = 1'b0;
    ctl.PCsrc = 1'b0;
    ctl.IRwrite = 1'b0;
    ctl.MemRead = 1'b0;
    ctl.MemWrite = 1'b0;
    ctl.ldA = 1'b0;
    ctl.ldB = 1'b0;
    ctl.push = 1'b0;
    ctl.pop = 1'b0;
    ctl.tos = 1'b0;
    ctl.ALUOperation = 3'b000;
    case (state_q)
      S_IF: begin
        ctl.srcA = 1'b1;
        ctl.srcB = 1'b1;
        ctl.ALUOperation = 3'b010;
        ctl.MemRead = 1'b1;
        ctl.PCwrite = mr;
        ctl.IRwrite = mr;
      end
      S_DEC: ctl.tos = 1'b1;
      S_JUMP: begin
        ctl.PCsrc = 1'b1;
        ctl.PCwrite = 1'b1;
      end
      S_JUMPZ: begin
        ctl.PCsrc = 1'b1;
        ctl.PCwritecond = 1'b1;
      end
      S_PUSH1: begin
        ctl.IorD = 1'b1;
        ctl.MemRead = 1'b1;
      end
      S_PUSH2: begin
        ctl.MtoS = 1'b1;
        ctl.push = 1'b1;
      end
      S_POP1, S_R0: ctl.pop = 1'b1;
      S_POP2: ctl.ldA = 1'b1;
      S_POP3: begin
        ctl.IorD = 1'b1;
        ctl.MemWrite = 1'b1;
      end
      S_R1: ctl.ldB = 1'b1;
      S_R2: ctl.ALUOperation = op == OP_SUB ? 3'b011 : op == OP_AND ? 3'b000 : op == OP_OR ? 3'b100 : 3'b010;
      S_RNOT: ctl.ALUOperation = 3'b001;
      S_REND: ctl.push = 1'b1;
      S_DUPA: ctl.ALUOperation = 3'b101;
      S_DUP1, S_DUP2: begin
        ctl.ALUOperation = 3'b101;
        ctl.push = 1'b1;
      end
      default: ctl.tos = 1'b0;
    endcase
  end
  assign depth_d = ctl.push ? depth_q + DW'(1) : ctl.pop ? depth_q - DW'(1) : depth_q;
  assign ctl.depth = depth_q;
  assign ctl.halted = state_q == S_HALT;
  assign ctl.trap = state_q == S_TRAP;
  assign ctl.trap_cause = cause_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      depth_q <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_stack_mc_controller_p.sv
// tb_stack_mc_controller_p: random and directed instruction streams checked cycle by cycle against a behavioural model
module tb_stack_mc_controller_p;
  localparam int DEPTH = 4;
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [14:0] B_IORD = 15'h4000, B_MTOS = 15'h2000, B_SRCA = 15'h1000, B_SRCB = 15'h0800,
                          B_PCW = 15'h0400, B_PCWC = 15'h0200, B_PCSRC = 15'h0100, B_IRW = 15'h0080,
                          B_MR = 15'h0040, B_MW = 15'h0020, B_LDA = 15'h0010, B_LDB = 15'h0008,
                          B_PUSH = 15'h0004, B_POP = 15'h0002, B_TOS = 15'h0001;
  localparam logic [14:0] FETCH = B_MR | B_SRCA | B_SRCB;
  typedef struct packed {
    logic mr;
    logic [14:0] s;
    logic [2:0] alu;
  } cyc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stack_mc_if #(.DW(DW)) bus ();
  stack_mc_controller_p #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .ctl(bus.master));
  always #5 clk = ~clk;
  cyc_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_depth = 0;
  int m_mode = 0;
  int m_cause = 0;
  int pend_fault;
  bit pend_halt;
  function automatic logic [14:0] got_s();
    return {bus.IorD, bus.MtoS, bus.srcA, bus.srcB, bus.PCwrite, bus.PCwritecond, bus.PCsrc, bus.IRwrite,
            bus.MemRead, bus.MemWrite, bus.ldA, bus.ldB, bus.push, bus.pop, bus.tos};
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic compare(input logic [14:0] s, input logic [2:0] alu);
    logic [25:0] g, e;
    g = {got_s(), bus.ALUOperation, 3'(bus.depth), bus.halted, bus.trap, bus.trap_cause};
    e = {s, alu, 3'(m_depth), m_mode == 1, m_mode == 2, 2'(m_cause)};
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle t=%0t: got strobes=%h alu=%0d depth=%0d h=%0b t=%0b cause=%0d, expected strobes=%h alu=%0d depth=%0d h=%0b t=%0b cause=%0d",
               $time, g[25:11], g[10:8], g[7:5], g[4], g[3], g[1:0], e[25:11], e[10:8], e[7:5], e[4], e[3], e[1:0]);
    end
  endtask
  task automatic add(input logic [14:0] s, input logic [2:0] alu, input logic mr);
    q.push_back('{mr: mr, s: s, alu: alu});
  endtask
  task automatic add_mem(input logic [14:0] s, input int waits);
    for (int i = 0; i < waits; i++) add(s, 3'd0, 1'b0);
    add(s, 3'd0, 1'b1);
  endtask
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic build(input int op, input int wf, input int wm);
    int need;
    q.delete();
    for (int i = 0; i < wf; i++) add(FETCH, 3'd2, 1'b0);
    add(FETCH | B_PCW | B_IRW, 3'd2, 1'b1);
    add(B_TOS, 3'd0, rnd());
    need = (op inside {0, 1, 2, 8}) ? 2 : (op inside {3, 5, 6, 7, 9}) ? 1 : 0;
    pend_fault = op > 10 ? 3 : m_depth < need ? 1 : ((op == 4 || op == 9) && m_depth == DEPTH) ? 2 : 0;
    pend_halt = pend_fault == 0 && op == 10;
    if (pend_fault != 0 || op == 10) return;
    case (op)
      6: add(B_PCSRC | B_PCW, 3'd0, rnd());
      7: add(B_PCSRC | B_PCWC, 3'd0, rnd());
      4: begin
        add_mem(B_IORD | B_MR, wm);
        add(B_MTOS | B_PUSH, 3'd0, rnd());
      end
      default: begin
        add(B_POP, 3'd0, rnd());
        add(B_LDA, 3'd0, rnd());
        if (op == 5) add_mem(B_IORD | B_MW, wm);
        else if (op == 3) begin
          add(15'd0, 3'd1, rnd());
          add(B_PUSH, 3'd0, rnd());
        end else if (op == 9) begin
          add(15'd0, 3'd5, rnd());
          add(B_PUSH, 3'd5, rnd());
          add(B_PUSH, 3'd5, rnd());
        end else begin
          add(B_POP, 3'd0, rnd());
          add(B_LDB, 3'd0, rnd());
          add(15'd0, op == 1 ? 3'd3 : op == 2 ? 3'd0 : op == 8 ? 3'd4 : 3'd2, rnd());
          add(B_PUSH, 3'd0, rnd());
        end
      end
    endcase
  endtask
  task automatic model_reset();
    m_depth = 0;
    m_mode = 0;
    m_cause = 0;
  endtask
  task automatic run(input int op, input int wf, input int wm, input bit allow_rst);
    cyc_t e;
    build(op, wf, wm);
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      @(negedge clk);
      if (i == 0) bus.Opcode = 4'(op);
      bus.mem_ready = e.mr;
      rst = allow_rst && $urandom_range(0, 59) == 0;
      #1 compare(e.s, e.alu);
      if (rst) begin
        model_reset();
        return;
      end
      m_depth += (e.s[2] ? 1 : 0) - (e.s[1] ? 1 : 0);
    end
    if (pend_fault != 0) begin
      m_mode = 2;
      m_cause = pend_fault;
    end else if (pend_halt) m_mode = 1;
  endtask
  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rnd();
      #1 compare(15'd0, 3'd0);
    end
  endtask
  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = rnd();
    #1 if (check) compare(15'd0, 3'd0);
    model_reset();
  endtask
  task automatic peek();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
  endtask
  initial begin
    int r, op;
    bus.Opcode = 4'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    peek();
    chk("reset MemRead", int'(bus.MemRead), 1);
    chk("reset ALUOperation", int'(bus.ALUOperation), 2);
    chk("reset PCwrite low", int'(bus.PCwrite), 0);
    chk("reset depth", int'(bus.depth), 0);
    chk("reset halted/trap", int'({bus.halted, bus.trap, bus.trap_cause}), 0);
    bus.mem_ready = 1'b1;
    #1 chk("reset PCwrite/IRwrite follow mem_ready", int'({bus.PCwrite, bus.IRwrite}), 3);
    bus.mem_ready = 1'b0;
    run(4, 0, 0, 0);
    run(4, 0, 0, 0);
    peek();
    chk("depth after two pushes", int'(bus.depth), 2);
    run(8, 3, 0, 0);
    peek();
    chk("depth after OR", int'(bus.depth), 1);
    run(0, 0, 0, 0);
    peek();
    chk("ADD underflow trap", int'(bus.trap), 1);
    chk("ADD underflow cause", int'(bus.trap_cause), 1);
    chk("ADD underflow no pop", int'(bus.depth), 1);
    run_idle(3);
    do_reset(1);
    peek();
    chk("trap cleared by reset", int'({bus.trap, bus.trap_cause, 3'(bus.depth)}), 0);
    run(13, 0, 0, 0);
    peek();
    chk("illegal beats underflow", int'(bus.trap_cause), 3);
    do_reset(1);
    for (int i = 0; i < 4; i++) run(4, 0, $urandom_range(0, 2), 0);
    run(9, 0, 0, 0);
    peek();
    chk("DUP overflow cause", int'(bus.trap_cause), 2);
    chk("DUP overflow depth", int'(bus.depth), 4);
    do_reset(1);
    for (int i = 0; i < 3; i++) run(4, 1, 1, 0);
    run(9, 0, 0, 0);
    peek();
    chk("DUP at depth 3 ends at 4", int'(bus.depth), 4);
    chk("DUP at depth 3 no trap", int'(bus.trap), 0);
    run(10, 0, 0, 0);
    run_idle(10);
    peek();
    chk("halted held", int'(bus.halted), 1);
    do_reset(1);
    peek();
    chk("reset leaves HALT", int'(bus.halted), 0);
    chk("reset depth after HALT", int'(bus.depth), 0);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      op = r < 3 ? $urandom_range(11, 15) : r < 5 ? 10 : r < 40 ? 4 : $urandom_range(0, 9);
      run(op, $urandom_range(0, 2), $urandom_range(0, 2), 1);
      if (m_mode != 0) begin
        run_idle($urandom_range(1, 4));
        do_reset(1);
      end
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
